// File: rtl/icache_burst.sv
// Direct-mapped instruction cache with multi-word lines and in-order burst refill.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_burst #(
  parameter int unsigned LINES          = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_WIDTH     = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        rom_ce_n_i,
  output logic [31:0] inst_o,
  output logic        stall_from_icache,
  input  logic        flush_i,
  output logic [31:0] sram_addr_o,
  output logic        sram_ce_n_o,
  input  logic        stall_from_bus,
  input  logic [31:0] inst_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int unsigned CNT_W   = (OFF_W > 0) ? OFF_W : 1;
  localparam int unsigned PAD_W   = CNT_W - OFF_W;
  localparam int unsigned IDX_W   = $clog2(LINES);
  localparam int unsigned TAG_W   = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam int unsigned LINE_SH = 2 + OFF_W;
  localparam int unsigned TAG_SH  = LINE_SH + IDX_W;
  localparam int unsigned DEPTH   = LINES * WORDS_PER_LINE;
  localparam int unsigned MEM_AW  = $clog2(DEPTH);
  localparam logic [31:0]      LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);
  localparam logic [31:0]      OFF_MASK  = 32'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t state, state_nxt;

  logic [31:0]       data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  logic [31:0]       base_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [CNT_W-1:0]  pc_off;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [MEM_AW-1:0] rd_ptr;
  logic [MEM_AW-1:0] wr_ptr;
  logic              lookup, hit, miss, beat, last_beat;

  // Address decode of the incoming fetch and of the line being refilled
  assign pc_off = CNT_W'((pc_i >> 2) & OFF_MASK);
  assign pc_idx = IDX_W'(pc_i >> LINE_SH);
  assign pc_tag = TAG_W'(pc_i >> TAG_SH);
  assign rd_ptr = MEM_AW'({pc_idx, pc_off} >> PAD_W);
  assign wr_ptr = MEM_AW'({idx_q, cnt_q} >> PAD_W);

  // Lookup is only meaningful in IDLE; a same-cycle flush forces a miss
  assign lookup    = (state == S_IDLE) && !rom_ce_n_i && !rst;
  assign hit       = lookup && !flush_i && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign miss      = lookup && !hit;
  assign beat      = (state == S_REFILL) && !stall_from_bus;
  assign last_beat = beat && (cnt_q == LAST_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (miss) state_nxt = S_REFILL;
      S_REFILL: if (flush_i || last_beat) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inst_o            = '0;
    stall_from_icache = 1'b0;
    sram_ce_n_o       = 1'b1;
    sram_addr_o       = '0;
    case (state)
      S_IDLE: begin
        if (hit)  inst_o = data_mem[rd_ptr];
        if (miss) stall_from_icache = 1'b1;
      end
      S_REFILL: begin
        stall_from_icache = 1'b1;
        sram_ce_n_o       = 1'b0;
        sram_addr_o       = base_q + (32'(cnt_q) << 2);
      end
      default: ;
    endcase
  end

  // Line bookkeeping; flush takes priority over both miss-invalidate and fill-complete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      base_q <= '0;
      idx_q  <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (flush_i)        valid          <= '0;
      else if (miss)      valid[pc_idx]  <= 1'b0;
      else if (last_beat) valid[idx_q]   <= 1'b1;

      if (miss) begin
        base_q <= pc_i & ~LINE_MASK;
        idx_q  <= pc_idx;
        tag_q  <= pc_tag;
        cnt_q  <= '0;
      end else if ((state == S_REFILL) && flush_i) begin
        cnt_q  <= '0;
      end else if (beat) begin
        cnt_q  <= last_beat ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat)      data_mem[wr_ptr] <= inst_i;
    if (last_beat) tag_mem[idx_q]   <= tag_q;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule
